multi_mode_ff_bank: RTL and testbench
=====================================

// Module: multi_mode_ff_bank
// PURPOSE
//   WIDTH-bit bank of mode-selectable flip-flops: the parametrised successor to the single-bit SR flip-flop.
//   One shared MODE input selects SR, JK, D or T behaviour for every bit. Bits update together under enable.
//   Adds a synchronous parallel load and sticky per-bit detection of the forbidden SR input (S=R=1).
//   A saturating counter records forbidden-input events. Used as a generic state register in small sequential tasks.
// PARAMETERS
//   WIDTH    4   number of flip-flop bits in the bank
//   CNT_W    8   width of the forbidden-event counter (saturating)
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous, active-low reset
//   en         in   1        update enable; 0 = hold all state
//   mode       in   2        00 SR, 01 JK, 10 D, 11 T
//   a          in   WIDTH    S / J / D / T input per bit
//   b          in   WIDTH    R / K input per bit; ignored in D and T modes
//   load       in   1        synchronous parallel load of load_val
//   load_val   in   WIDTH    value written on load
//   err_clr    in   1        clears err_flag; does not clear the counter
//   q          out  WIDTH    flip-flop outputs
//   qn         out  WIDTH    ~q, purely combinational from q
//   err_flag   out  WIDTH    sticky: bit i saw S=R=1 in SR mode
//   err_cnt    out  CNT_W    number of enabled cycles with any forbidden bit
// BEHAVIOUR
//   - Reset: asserting rst_n=0 asynchronously forces q=0, err_flag=0 and err_cnt=0. Release is synchronous to clk.
//   - All state is registered. q reflects the inputs one rising edge after they are sampled. No combinational path from inputs to q.
//   - Priority per edge: load > en > hold.
//     load=1 -> q<=load_val regardless of en and mode; no error detection that cycle.
//   - en=1, load=0, per bit i:
//       SR: 00 hold, 10 set, 01 clear, 11 hold q[i] and raise error
//       JK: 00 hold, 10 set, 01 clear, 11 toggle
//       D : q[i]<=a[i]
//       T : a[i]=1 toggles q[i], a[i]=0 holds
//   - en=0, load=0: q, err_flag and err_cnt hold. No error detection.
//   - err_flag[i] is set on an edge with en=1, load=0, mode=SR and a[i]&b[i]=1.
//   - err_clr=1 clears all err_flag bits, except bits being set on the same edge. Set wins over clear.
//   - err_cnt increments by 1 on each edge where at least one bit raises an error. It counts cycles, not bits.
//     It saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.
//   - A mode change takes effect on the next edge. No settling cycles.
//   - Reset asserted mid-sequence aborts immediately. The first edge after release behaves normally.
// STRUCTURE
//   - Shared package/include holds:
//       mode localparams MODE_SR=2'b00, MODE_JK=2'b01, MODE_D=2'b10, MODE_T=2'b11;
//       next-state function ff_next(mode, q, a, b).
//   - One sub-module mm_ff_cell: a single bit with its own q and sticky err register, plus a raw "forbidden now" output.
//     Instantiate WIDTH copies with generate.
//   - Top level holds the saturating err_cnt, the OR-reduction of the raw error outputs, and the qn inversion.
// TESTING (WIDTH=4, CNT_W=2)
//   - Reset: assert rst_n=0 mid-clock -> q=0000, qn=1111, err_flag=0, err_cnt=0 immediately, before the next edge.
//   - SR sequence on all bits: a/b = 0/0, F/0, 0/F, F/F, each for one edge ->
//     q = 0000, 1111, 0000, 0000 (held); err_flag=1111; err_cnt=1.
//   - JK with q=0101, a=F, b=F -> 1010, then 0101.
//     D with a=1100 -> 1100. T with a=0011 from 1100 -> 1111.
//   - Load and enable: en=0, a=F in D mode -> q holds.
//     load=1, load_val=1001 with en=0 and with en=1 -> q=1001 both times.
//   - Errors: err_clr together with a new SR 11 on bit0 -> err_flag=0001.
//     Four more forbidden cycles -> err_cnt saturates at 3 and stays at 3.

Source files
------------

// File: rtl/multi_mode_ff_bank_pkg.sv
// Shared mode encodings and the per-bit next-state function for the mode-selectable flip-flop bank.
// Pure combinational helpers; no state, no latency, no backpressure.
package multi_mode_ff_bank_pkg;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  // SR 11 holds q; the error side effect is handled by the cell, not here.
  function automatic logic ff_next(input logic [1:0] mode, input logic q,
                                   input logic a, input logic b);
    logic nxt;
    nxt = q;
    case (mode)
      MODE_SR: begin
        case ({a, b})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          default: nxt = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      MODE_D:  nxt = a;
      default: nxt = q ^ a;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multi_mode_ff_bank_cell.sv
// One bank bit: mode-selectable flip-flop plus sticky forbidden-input flag; q updates one edge after sampling.
// No backpressure: en=0 holds state, load overrides everything.
module mm_ff_cell
  import multi_mode_ff_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       load,
  input  logic       load_val,
  input  logic       err_clr,
  output logic       q,
  output logic       err_flag,
  output logic       forbidden
);

  // Raw strobe: only an enabled, non-load SR cycle can be forbidden.
  assign forbidden = en && !load && (mode == MODE_SR) && a && b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= ff_next(mode, q, a, b);
    end
  end

  // Set wins over clear so an event on the clearing edge is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
    end else if (forbidden) begin
      err_flag <= 1'b1;
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit bank of SR/JK/D/T flip-flops with parallel load, sticky error flags and a saturating error counter.
// Latency one edge; no backpressure (en=0 holds, load has priority over en).
module multi_mode_ff_bank
  import multi_mode_ff_bank_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] err_flag,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] forbidden;
  logic             any_err;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    mm_ff_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .a         (a[i]),
      .b         (b[i]),
      .load      (load),
      .load_val  (load_val[i]),
      .err_clr   (err_clr),
      .q         (q[i]),
      .err_flag  (err_flag[i]),
      .forbidden (forbidden[i])
    );
  end

  assign qn      = ~q;
  assign any_err = |forbidden;

  // Counts cycles with any forbidden bit, not bits; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (any_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench for multi_mode_ff_bank (WIDTH=4, CNT_W=2) with a queue of expected results.
// Expectations are pushed as each step is driven and popped after the sampling edge.
module tb_multi_mode_ff_bank;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  localparam logic [1:0] M_SR = 2'b00;
  localparam logic [1:0] M_JK = 2'b01;
  localparam logic [1:0] M_D  = 2'b10;
  localparam logic [1:0] M_T  = 2'b11;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] err_flag;
  logic [CNT_W-1:0] err_cnt;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  multi_mode_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .load     (load),
    .load_val (load_val),
    .err_clr  (err_clr),
    .q        (q),
    .qn       (qn),
    .err_flag (err_flag),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic compare(input exp_t e);
    logic [WIDTH-1:0] exp_qn;
    exp_qn = ~e.q;
    checks++;
    assert (q === e.q) else begin
      failures++;
      $error("FAIL %s q: got %b want %b", e.tag, q, e.q);
    end
    checks++;
    assert (qn === exp_qn) else begin
      failures++;
      $error("FAIL %s qn: got %b want %b", e.tag, qn, exp_qn);
    end
    checks++;
    assert (err_flag === e.err) else begin
      failures++;
      $error("FAIL %s err_flag: got %b want %b", e.tag, err_flag, e.err);
    end
    checks++;
    assert (err_cnt === e.cnt) else begin
      failures++;
      $error("FAIL %s err_cnt: got %0d want %0d", e.tag, err_cnt, e.cnt);
    end
  endtask

  // Drive one edge worth of inputs, queue its expectation, then check after the edge.
  task automatic step(input string tag, input logic s_en, input logic [1:0] s_mode,
                      input logic [WIDTH-1:0] s_a, input logic [WIDTH-1:0] s_b,
                      input logic s_load, input logic [WIDTH-1:0] s_lv, input logic s_clr,
                      input logic [WIDTH-1:0] e_q, input logic [WIDTH-1:0] e_err,
                      input logic [CNT_W-1:0] e_cnt);
    exp_t e;
    en = s_en; mode = s_mode; a = s_a; b = s_b;
    load = s_load; load_val = s_lv; err_clr = s_clr;
    e.tag = tag; e.q = e_q; e.err = e_err; e.cnt = e_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: queue empty, want 1 entry", tag);
    end else begin
      compare(exp_q.pop_front());
    end
  endtask

  task automatic check_reset(input string tag);
    exp_t e;
    e.tag = tag; e.q = '0; e.err = '0; e.cnt = '0;
    exp_q.push_back(e);
    compare(exp_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = M_SR; a = '0; b = '0;
    load = 1'b0; load_val = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset mid-cycle, checked before any further edge.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    //    tag            en   mode  a        b        ld   lv       clr   q        err      cnt
    step("sr_00",       1'b1, M_SR, 4'h0,   4'h0,   1'b0, 4'h0,   1'b0, 4'b0000, 4'b0000, 2'd0);
    step("sr_set",      1'b1, M_SR, 4'hF,   4'h0,   1'b0, 4'h0,   1'b0, 4'b1111, 4'b0000, 2'd0);
    step("sr_clr",      1'b1, M_SR, 4'h0,   4'hF,   1'b0, 4'h0,   1'b0, 4'b0000, 4'b0000, 2'd0);
    step("sr_11",       1'b1, M_SR, 4'hF,   4'hF,   1'b0, 4'h0,   1'b0, 4'b0000, 4'b1111, 2'd1);
    step("load_0101",   1'b1, M_SR, 4'h0,   4'h0,   1'b1, 4'h5,   1'b0, 4'b0101, 4'b1111, 2'd1);
    step("jk_tog1",     1'b1, M_JK, 4'hF,   4'hF,   1'b0, 4'h0,   1'b0, 4'b1010, 4'b1111, 2'd1);
    step("jk_tog2",     1'b1, M_JK, 4'hF,   4'hF,   1'b0, 4'h0,   1'b0, 4'b0101, 4'b1111, 2'd1);
    step("d_1100",      1'b1, M_D,  4'hC,   4'h3,   1'b0, 4'h0,   1'b0, 4'b1100, 4'b1111, 2'd1);
    step("t_0011",      1'b1, M_T,  4'h3,   4'hF,   1'b0, 4'h0,   1'b0, 4'b1111, 4'b1111, 2'd1);
    step("en0_d_hold",  1'b0, M_D,  4'h0,   4'h0,   1'b0, 4'h0,   1'b0, 4'b1111, 4'b1111, 2'd1);
    step("en0_sr_noerr",1'b0, M_SR, 4'hF,   4'hF,   1'b0, 4'h0,   1'b0, 4'b1111, 4'b1111, 2'd1);
    step("load_en0",    1'b0, M_D,  4'hF,   4'h0,   1'b1, 4'h9,   1'b0, 4'b1001, 4'b1111, 2'd1);
    step("d_zero",      1'b1, M_D,  4'h0,   4'h0,   1'b0, 4'h0,   1'b0, 4'b0000, 4'b1111, 2'd1);
    step("load_en1_sr", 1'b1, M_SR, 4'hF,   4'hF,   1'b1, 4'h9,   1'b0, 4'b1001, 4'b1111, 2'd1);
    step("clr_set_wins",1'b1, M_SR, 4'h1,   4'h1,   1'b0, 4'h0,   1'b1, 4'b1001, 4'b0001, 2'd2);
    step("clr_only",    1'b1, M_D,  4'h9,   4'h0,   1'b0, 4'h0,   1'b1, 4'b1001, 4'b0000, 2'd2);
    step("forb_1",      1'b1, M_SR, 4'h2,   4'h2,   1'b0, 4'h0,   1'b0, 4'b1001, 4'b0010, 2'd3);
    step("forb_2_sat",  1'b1, M_SR, 4'h2,   4'h2,   1'b0, 4'h0,   1'b0, 4'b1001, 4'b0010, 2'd3);
    step("forb_3_sat",  1'b1, M_SR, 4'hF,   4'hF,   1'b0, 4'h0,   1'b0, 4'b1001, 4'b1111, 2'd3);
    step("forb_4_sat",  1'b1, M_SR, 4'hF,   4'hF,   1'b0, 4'h0,   1'b0, 4'b1001, 4'b1111, 2'd3);
    step("mode_switch", 1'b1, M_T,  4'hF,   4'h0,   1'b0, 4'h0,   1'b0, 4'b0110, 4'b1111, 2'd3);

    // Reset in the middle of a sequence, then the first edge after release.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_d",1'b1, M_D,  4'h7,   4'h0,   1'b0, 4'h0,   1'b0, 4'b0111, 4'b0000, 2'd0);
    step("post_reset_sr",1'b1,M_SR, 4'h8,   4'h8,   1'b0, 4'h0,   1'b0, 4'b0111, 4'b1000, 2'd1);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
